// File: rtl/blake2_pkg.sv
// rtl/blake2_pkg.sv - shared BLAKE2 constants, parameter sets and sequencer state encoding
package blake2_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_KEY  = 3'd1,
    S_KPAD = 3'd2,
    S_MSG  = 3'd3,
    S_PAD  = 3'd4,
    S_HASH = 3'd5
  } state_t;

  localparam int BLOCK_BYTES = 64;

  // blake2s / blake2b parameter sets: word width, rounds, G rotations
  localparam int W_S = 32, R_S = 10, R1_S = 16, R2_S = 12, R3_S = 8,  R4_S = 7;
  localparam int W_B = 64, R_B = 12, R1_B = 32, R2_B = 24, R3_B = 16, R4_B = 63;

  // word 0 in the least significant position
  localparam logic [255:0] IV_S = {
    32'h5BE0CD19, 32'h1F83D9AB, 32'h9B05688C, 32'h510E527F,
    32'hA54FF53A, 32'h3C6EF372, 32'hBB67AE85, 32'h6A09E667};
  localparam logic [511:0] IV_B = {
    64'h5BE0CD19137E2179, 64'h1F83D9ABFB41BD6B, 64'h9B05688C2B3E6C1F, 64'h510E527FADE682D1,
    64'hA54FF53A5F1D36F1, 64'h3C6EF372FE94F82B, 64'hBB67AE8584CAA73B, 64'h6A09E667F3BCC908};

  // row r in bits [64r +: 64], element i of a row in nibble i
  localparam logic [639:0] SIGMA = {
    64'h0DC3E9BF5167482A, 64'h5A417D2C803B9EF6, 64'hA2684F05931CE7BD, 64'hB8293670A4DEF15C,
    64'h91EF57D438B0A6C2, 64'hD386CB1EFA427509, 64'h8F04A562EBCD1397, 64'h491763EADF250C8B,
    64'h357B20C16DF984AE, 64'hFEDCBA9876543210};

  function automatic logic [3:0] sigma(input int unsigned r, input int unsigned i);
    return SIGMA[(64 * (r % 10)) + (4 * i) +: 4];
  endfunction

endpackage

// File: rtl/blake2_out_fwd.sv
// rtl/blake2_out_fwd.sv - digest byte pass-through with byte counter and last marker
module blake2_out_fwd #(
  parameter int LEN_W = 7
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             en_i,
  input  logic [LEN_W-1:0] nn_i,
  input  logic             h_v_i,
  input  logic [7:0]       h_i,
  output logic             m_valid_o,
  output logic [7:0]       m_data_o,
  output logic             m_last_o,
  output logic             done_o
);

  logic [LEN_W-1:0] out_cnt_q, out_cnt_d;

  assign m_valid_o = en_i & h_v_i;
  assign m_data_o  = m_valid_o ? h_i : 8'h00;
  assign m_last_o  = m_valid_o && ((out_cnt_q + LEN_W'(1)) == nn_i);
  assign done_o    = m_last_o;

  always_comb begin
    out_cnt_d = out_cnt_q;
    if (m_last_o)       out_cnt_d = '0;
    else if (m_valid_o) out_cnt_d = out_cnt_q + LEN_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!nreset) out_cnt_q <= '0;
    else         out_cnt_q <= out_cnt_d;
  end

endmodule

// File: rtl/blake2_msg_sched.sv
// rtl/blake2_msg_sched.sv - byte-stream to blake2 core sequencer: key/message blocking,
// zero padding, first/last/ll generation and digest forwarding
module blake2_msg_sched #(
  parameter int W           = 32,
  parameter int BLOCK_BYTES = blake2_pkg::BLOCK_BYTES,
  parameter int IDX_W       = 7,
  parameter int LEN_W       = 7,
  parameter int LL_W        = 2 * W
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             start_i,
  input  logic [LEN_W-1:0] kk_i,
  input  logic [LEN_W-1:0] nn_i,
  input  logic             empty_i,
  input  logic             s_valid_i,
  input  logic [7:0]       s_data_i,
  input  logic             s_last_i,
  output logic             s_ready_o,
  output logic [LEN_W-1:0] core_kk_o,
  output logic [LEN_W-1:0] core_nn_o,
  output logic [LL_W-1:0]  core_ll_o,
  output logic             core_first_o,
  output logic             core_last_o,
  output logic             core_data_v_o,
  output logic [IDX_W-1:0] core_idx_o,
  output logic [7:0]       core_data_o,
  input  logic             core_ready_i,
  input  logic             core_h_v_i,
  input  logic [7:0]       core_h_i,
  output logic             m_valid_o,
  output logic [7:0]       m_data_o,
  output logic             m_last_o,
  output logic             busy_o
);
  import blake2_pkg::*;

  state_t           state_q;
  logic [LEN_W-1:0] kk_q, nn_q, key_cnt_q;
  logic             empty_q, blk_first_q;
  logic [IDX_W-1:0] byte_idx_q;
  logic [LL_W-1:0]  ll_q;

  logic stream_st, pad_st, src_valid, xfer, wrap, key_done, hash_done;

  // upstream feeds key/message states; pad states source a constant zero byte
  assign stream_st = (state_q == S_KEY) || (state_q == S_MSG);
  assign pad_st    = (state_q == S_KPAD) || (state_q == S_PAD);
  assign src_valid = stream_st ? s_valid_i : pad_st;
  assign xfer      = src_valid & core_ready_i;
  assign wrap      = (byte_idx_q == IDX_W'(BLOCK_BYTES - 1));
  assign key_done  = ((key_cnt_q + LEN_W'(1)) == kk_q);

  assign s_ready_o     = core_ready_i & stream_st;
  assign core_data_v_o = xfer;
  assign core_data_o   = stream_st ? s_data_i : 8'h00;
  assign core_idx_o    = byte_idx_q;
  assign core_first_o  = blk_first_q;
  assign core_kk_o     = kk_q;
  assign core_nn_o     = nn_q;
  assign core_ll_o     = ll_q;
  assign busy_o        = (state_q != S_IDLE);

  always_comb begin
    core_last_o = 1'b0;
    case (state_q)
      S_PAD:          core_last_o = 1'b1;
      S_MSG:          core_last_o = s_valid_i & s_last_i;
      S_KEY, S_KPAD:  core_last_o = empty_q;
      default:        core_last_o = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q     <= S_IDLE;
      kk_q        <= '0;
      nn_q        <= '0;
      key_cnt_q   <= '0;
      empty_q     <= 1'b0;
      blk_first_q <= 1'b0;
      byte_idx_q  <= '0;
      ll_q        <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (start_i) begin
          kk_q        <= kk_i;
          nn_q        <= nn_i;
          empty_q     <= empty_i;
          key_cnt_q   <= '0;
          byte_idx_q  <= '0;
          blk_first_q <= 1'b1;
          ll_q        <= '0;
          state_q     <= (kk_i != '0) ? S_KEY : (empty_i ? S_PAD : S_MSG);
        end
        S_KEY: if (xfer) begin
          key_cnt_q <= key_cnt_q + LEN_W'(1);
          if (key_done) begin
            if (wrap) begin
              ll_q    <= ll_q + LL_W'(BLOCK_BYTES);
              state_q <= empty_q ? S_HASH : S_MSG;
            end else begin
              state_q <= S_KPAD;
            end
          end
        end
        S_KPAD: if (xfer && wrap) begin
          ll_q    <= ll_q + LL_W'(BLOCK_BYTES);
          state_q <= empty_q ? S_HASH : S_MSG;
        end
        S_MSG: if (xfer) begin
          ll_q <= ll_q + LL_W'(1);
          if (s_last_i) state_q <= wrap ? S_HASH : S_PAD;
        end
        S_PAD:  if (xfer && wrap) state_q <= S_HASH;
        S_HASH: if (hash_done)    state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
      if (xfer) begin
        byte_idx_q <= wrap ? '0 : byte_idx_q + IDX_W'(1);
        if (wrap) blk_first_q <= 1'b0;
      end
    end
  end

  blake2_out_fwd #(.LEN_W(LEN_W)) u_out_fwd (
    .clk       (clk),
    .nreset    (nreset),
    .en_i      (state_q == S_HASH),
    .nn_i      (nn_q),
    .h_v_i     (core_h_v_i),
    .h_i       (core_h_i),
    .m_valid_o (m_valid_o),
    .m_data_o  (m_data_o),
    .m_last_o  (m_last_o),
    .done_o    (hash_done)
  );

endmodule

// File: tb/tb_blake2_msg_sched.sv
// tb/tb_blake2_msg_sched.sv - directed bench for blake2_msg_sched with a behavioural core stub
module tb_blake2_msg_sched;

  logic        clk = 1'b0;
  logic        nreset, start_i, empty_i, s_valid_i, s_last_i, s_ready_o;
  logic [6:0]  kk_i, nn_i, core_kk_o, core_nn_o, core_idx_o;
  logic [7:0]  s_data_i, core_data_o, core_h_i, m_data_o;
  logic [63:0] core_ll_o;
  logic        core_first_o, core_last_o, core_data_v_o, core_ready_i, core_h_v_i;
  logic        m_valid_o, m_last_o, busy_o;

  int vectors = 0;
  int miscompares = 0;
  int sready_cnt = 0;

  logic [7:0] msg[$];
  logic [7:0] rec_d[$];
  logic [6:0] rec_i[$];
  logic       rec_f[$];
  logic       rec_l[$];

  always #5 clk = ~clk;

  blake2_msg_sched dut (
    .clk(clk), .nreset(nreset), .start_i(start_i), .kk_i(kk_i), .nn_i(nn_i),
    .empty_i(empty_i), .s_valid_i(s_valid_i), .s_data_i(s_data_i), .s_last_i(s_last_i),
    .s_ready_o(s_ready_o), .core_kk_o(core_kk_o), .core_nn_o(core_nn_o),
    .core_ll_o(core_ll_o), .core_first_o(core_first_o), .core_last_o(core_last_o),
    .core_data_v_o(core_data_v_o), .core_idx_o(core_idx_o), .core_data_o(core_data_o),
    .core_ready_i(core_ready_i), .core_h_v_i(core_h_v_i), .core_h_i(core_h_i),
    .m_valid_o(m_valid_o), .m_data_o(m_data_o), .m_last_o(m_last_o), .busy_o(busy_o)
  );

  // core-side transfer log, sampled mid-cycle
  always @(negedge clk) begin
    if (core_data_v_o) begin
      rec_d.push_back(core_data_o);
      rec_i.push_back(core_idx_o);
      rec_f.push_back(core_first_o);
      rec_l.push_back(core_last_o);
    end
    if (s_ready_o) sready_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_cmd(input int kk, input int nn, input logic empty);
    kk_i = 7'(kk); nn_i = 7'(nn); empty_i = empty; start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic push(input logic [7:0] d, input logic l);
    int n = 0;
    s_valid_i = 1'b1; s_data_i = d; s_last_i = l;
    #1;
    while (!s_ready_o && n < 100) begin
      tick();
      n++;
    end
    chk("push_bound", 64'(n < 100), 64'd1);
    tick();
    s_valid_i = 1'b0; s_last_i = 1'b0;
  endtask

  task automatic wait_xfers(input int target);
    int n = 0;
    while (rec_d.size() < target && n < 400) begin
      tick();
      n++;
    end
    chk("xfer_count", 64'(rec_d.size()), 64'(target));
  endtask

  task automatic feed(input int kk);
    for (int i = 0; i < kk; i++) push(8'(i), 1'b0);
    for (int i = 0; i < msg.size(); i++) push(msg[i], i == msg.size() - 1);
  endtask

  task automatic digest(input int nn, input logic [31:0] hb, input logic gap);
    for (int i = 0; i < nn; i++) begin
      logic [7:0] b;
      if (gap && i == 2) begin
        core_h_v_i = 1'b0;
        #1;
        chk("m_valid_gap", 64'(m_valid_o), 64'd0);
        tick();
      end
      b = (i < 4) ? hb[31 - 8*i -: 8] : 8'(i * 3 + 1);
      core_h_v_i = 1'b1; core_h_i = b;
      #1;
      chk("m_valid", 64'(m_valid_o), 64'd1);
      chk("m_data", 64'(m_data_o), 64'(b));
      chk("m_last", 64'(m_last_o), 64'(i == nn - 1));
      tick();
    end
    core_h_v_i = 1'b0;
    #1;
    chk("busy_after_digest", 64'(busy_o), 64'd0);
  endtask

  // expected core stream: optional key block, then message blocks zero-padded to 64
  task automatic verify(input int base, input int kk, input logic empty, input int nn,
                        input logic [31:0] hb, input logic gap);
    int nmsg  = msg.size();
    int nkey  = (kk > 0) ? 64 : 0;
    int nblk  = empty ? ((kk > 0) ? 0 : 1) : (nmsg + 63) / 64;
    int total = nkey + 64 * nblk;
    wait_xfers(base + total);
    for (int j = 0; j < total && base + j < rec_d.size(); j++) begin
      int k = base + j;
      chk("core_idx", 64'(rec_i[k]), 64'(j % 64));
      chk("core_first", 64'(rec_f[k]), 64'(j < 64));
      if (j < nkey) begin
        chk("key_data", 64'(rec_d[k]), (j < kk) ? 64'(j) : 64'd0);
        chk("key_last", 64'(rec_l[k]), 64'(empty));
      end else begin
        int m = j - nkey;
        chk("msg_data", 64'(rec_d[k]), (m < nmsg) ? 64'(msg[m]) : 64'd0);
        if (empty || m >= nmsg - 1) chk("msg_last", 64'(rec_l[k]), 64'd1);
        else                         chk("msg_last", 64'(rec_l[k]), 64'd0);
      end
    end
    tick(); tick();
    chk("no_extra_xfer", 64'(rec_d.size()), 64'(base + total));
    chk("busy_in_hash", 64'(busy_o), 64'd1);
    chk("core_ll", core_ll_o, 64'(nkey + nmsg));
    chk("core_kk", 64'(core_kk_o), 64'(kk));
    chk("core_nn", 64'(core_nn_o), 64'(nn));
    digest(nn, hb, gap);
  endtask

  task automatic run_abc();
    int base = rec_d.size();
    msg.delete();
    msg.push_back(8'h61); msg.push_back(8'h62); msg.push_back(8'h63);
    start_cmd(0, 32, 1'b0);
    feed(0);
    verify(base, 0, 1'b0, 32, 32'h508c5e8c, 1'b1);
  endtask

  initial begin
    int base, sr0;
    nreset = 1'b0; start_i = 1'b0; kk_i = '0; nn_i = '0; empty_i = 1'b0;
    s_valid_i = 1'b0; s_data_i = '0; s_last_i = 1'b0;
    core_ready_i = 1'b1; core_h_v_i = 1'b0; core_h_i = '0;
    tick(); tick();
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_s_ready", 64'(s_ready_o), 64'd0);
    chk("rst_data_v", 64'(core_data_v_o), 64'd0);
    chk("rst_first", 64'(core_first_o), 64'd0);
    chk("rst_last", 64'(core_last_o), 64'd0);
    chk("rst_ll", core_ll_o, 64'd0);
    chk("rst_m_valid", 64'(m_valid_o), 64'd0);
    chk("rst_m_last", 64'(m_last_o), 64'd0);
    nreset = 1'b1;
    tick();

    run_abc();

    // unkeyed empty message: single zero block, upstream never readied
    base = rec_d.size(); sr0 = sready_cnt; msg.delete();
    start_cmd(0, 32, 1'b1);
    verify(base, 0, 1'b1, 32, 32'h69217a30, 1'b0);
    chk("empty_no_s_ready", 64'(sready_cnt), 64'(sr0));

    // exactly one full block, no padding block, 4-byte digest
    base = rec_d.size(); msg.delete();
    for (int i = 0; i < 64; i++) msg.push_back(8'(i + 1));
    start_cmd(0, 4, 1'b0);
    feed(0);
    verify(base, 0, 1'b0, 4, 32'hdeadbeef, 1'b0);

    // 65 bytes spill one byte into a padded second block, 1-byte digest
    base = rec_d.size(); msg.delete();
    for (int i = 0; i < 65; i++) msg.push_back(8'(i ^ 8'h5a));
    start_cmd(0, 1, 1'b0);
    feed(0);
    verify(base, 0, 1'b0, 1, 32'ha5000000, 1'b0);

    // keyed: 32-byte key 00..1f, message 0x00
    base = rec_d.size(); msg.delete();
    msg.push_back(8'h00);
    start_cmd(32, 32, 1'b0);
    feed(32);
    verify(base, 32, 1'b0, 32, 32'h40d15fee, 1'b0);

    // core stall at idx 20, then upstream gap after idx 21
    base = rec_d.size(); msg.delete();
    for (int i = 0; i < 30; i++) msg.push_back(8'(8'h80 + i));
    start_cmd(0, 32, 1'b0);
    for (int i = 0; i < 20; i++) push(msg[i], 1'b0);
    core_ready_i = 1'b0; s_valid_i = 1'b1; s_data_i = msg[20]; s_last_i = 1'b0;
    for (int c = 0; c < 10; c++) begin
      #1;
      chk("stall_data_v", 64'(core_data_v_o), 64'd0);
      chk("stall_s_ready", 64'(s_ready_o), 64'd0);
      chk("stall_idx", 64'(core_idx_o), 64'd20);
      tick();
    end
    chk("stall_xfers", 64'(rec_d.size()), 64'(base + 20));
    core_ready_i = 1'b1;
    push(msg[20], 1'b0);
    push(msg[21], 1'b0);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("gap_data_v", 64'(core_data_v_o), 64'd0);
      tick();
    end
    for (int i = 22; i < 30; i++) push(msg[i], i == 29);
    verify(base, 0, 1'b0, 32, 32'h01020304, 1'b0);

    // reset at idx 30 of block 0 aborts the run
    base = rec_d.size();
    start_cmd(0, 32, 1'b0);
    for (int i = 0; i < 30; i++) push(8'(i), 1'b0);
    chk("pre_reset_idx", 64'(core_idx_o), 64'd30);
    nreset = 1'b0;
    tick();
    nreset = 1'b1;
    #1;
    chk("abort_busy", 64'(busy_o), 64'd0);
    chk("abort_data_v", 64'(core_data_v_o), 64'd0);
    chk("abort_s_ready", 64'(s_ready_o), 64'd0);
    chk("abort_first", 64'(core_first_o), 64'd0);
    chk("abort_last", 64'(core_last_o), 64'd0);
    chk("abort_ll", core_ll_o, 64'd0);
    chk("abort_m_valid", 64'(m_valid_o), 64'd0);
    tick(); tick(); tick();
    chk("abort_no_xfer", 64'(rec_d.size()), 64'(base + 30));
    run_abc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
